// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined main memory between I/D block fills and D write-through stores.
// Fixed priority store > D fill > I fill, no preemption, one operation at a time.
module mem_arbiter #(
   parameter int MEM_LAT = 4,
   parameter int WORDS   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [15:0] i_addr,
   input  logic        d_req,
   input  logic [15:0] d_addr,
   input  logic        d_wr_req,
   input  logic [15:0] d_wr_addr,
   input  logic [15:0] d_wr_data,
   output logic        i_done,
   output logic        d_done,
   output logic        d_wr_done,
   output logic        i_fill_we,
   output logic        d_fill_we,
   output logic [15:0] fill_addr,
   output logic [15:0] fill_data,
   output logic        mem_enable,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_data_in,
   input  logic [15:0] mem_data_out,
   input  logic        mem_data_valid,
   output logic        busy
);
   localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [15:0] MASK = ~16'(2 * WORDS - 1);
   localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

   if (MEM_LAT < 1 || (WORDS & (WORDS - 1)) != 0) begin : g_bad_params
      $error("mem_arbiter: MEM_LAT must be >= 1 and WORDS a power of two");
   end

   typedef enum logic [2:0] {IDLE, WRITE, FILL_ISSUE, FILL_DRAIN, DONE} state_t;
   state_t state, state_n;

   logic          owner_d;
   logic [15:0]   base, wr_addr, wr_data;
   logic [CW-1:0] issue_cnt, rx_cnt;
   logic          cap, run;

   // returns are only consumed while a fill is outstanding; anything else is stale
   assign cap = (state == FILL_ISSUE || state == FILL_DRAIN) && mem_data_valid;
   assign run = !rst;

   always_ff @(posedge clk)
      state <= rst ? IDLE : state_n;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:       state_n = d_wr_req ? WRITE : (d_req || i_req) ? FILL_ISSUE : IDLE;
         WRITE:      state_n = IDLE;
         FILL_ISSUE: state_n = (cap && rx_cnt == LAST) ? DONE : (issue_cnt == LAST) ? FILL_DRAIN : FILL_ISSUE;
         FILL_DRAIN: state_n = (cap && rx_cnt == LAST) ? DONE : FILL_DRAIN;
         default:    state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk)
      if (rst) begin
         owner_d   <= 1'b0;
         base      <= '0;
         wr_addr   <= '0;
         wr_data   <= '0;
         issue_cnt <= '0;
         rx_cnt    <= '0;
      end else begin
         if (state == IDLE && d_wr_req) begin
            wr_addr <= d_wr_addr;
            wr_data <= d_wr_data;
         end else if (state == IDLE && (d_req || i_req)) begin
            owner_d   <= d_req;
            base      <= (d_req ? d_addr : i_addr) & MASK;
            issue_cnt <= '0;
            rx_cnt    <= '0;
         end
         if (state == FILL_ISSUE) issue_cnt <= issue_cnt + 1'b1;
         if (cap) rx_cnt <= rx_cnt + 1'b1;
      end

   // every output is forced low while rst is high, even before the state register clears
   always_comb begin
      busy        = run && state != IDLE;
      mem_wr      = run && state == WRITE;
      mem_enable  = run && (state == WRITE || state == FILL_ISSUE);
      mem_addr    = mem_wr ? wr_addr : mem_enable ? base + 16'({issue_cnt, 1'b0}) : '0;
      mem_data_in = mem_wr ? wr_data : '0;
      d_wr_done   = mem_wr;
      i_fill_we   = run && cap && !owner_d;
      d_fill_we   = run && cap && owner_d;
      fill_addr   = (run && cap) ? base + 16'({rx_cnt, 1'b0}) : '0;
      fill_data   = (run && cap) ? mem_data_out : '0;
      i_done      = run && state == DONE && !owner_d;
      d_done      = run && state == DONE && owner_d;
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-timeline
// reference model and an in-order pipelined memory model with optional return jitter.
module tb_mem_arbiter;
   localparam int MEM_LAT = 4;
   localparam int WORDS   = 8;

   logic        clk = 0, rst = 1;
   logic        i_req = 0, d_req = 0, d_wr_req = 0;
   logic [15:0] i_addr = 0, d_addr = 0, d_wr_addr = 0, d_wr_data = 0;
   logic        i_done, d_done, d_wr_done, i_fill_we, d_fill_we, mem_enable, mem_wr, busy;
   logic [15:0] fill_addr, fill_data, mem_addr, mem_data_in;
   logic [15:0] mem_data_out = 0;
   logic        mem_data_valid = 0;

   mem_arbiter #(.MEM_LAT(MEM_LAT), .WORDS(WORDS)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr),
      .d_req(d_req), .d_addr(d_addr),
      .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
      .i_done(i_done), .d_done(d_done), .d_wr_done(d_wr_done),
      .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
      .fill_addr(fill_addr), .fill_data(fill_data),
      .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
      .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef enum {NONE, ST, FILL} op_t;
   typedef struct {int due; logic [15:0] d;} rd_t;

   op_t         op = NONE;
   logic        f_d = 0;
   logic [15:0] f_base = 0, s_addr = 0, s_data = 0;
   int          m_t = 0, m_rx = 0, cyc = 0, n_chk = 0, n_err = 0;
   bit          jitter = 0, p_idle = 1, p_rst = 1;
   logic [15:0] mem_w [logic [15:0]];
   rd_t         rq[$];
   int          done_log[$];

   function automatic logic [15:0] mword(input logic [15:0] a);
      return mem_w.exists(a) ? mem_w[a] : (a * 16'h9E37) ^ 16'h5A5A;
   endfunction

   function automatic logic [15:0] log_code();
      logic [15:0] v = 0;
      foreach (done_log[k]) v = (v << 4) | 16'(done_log[k]);
      return v;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock cycle: inputs are stable from the previous posedge until here, so the model
   // grants with exactly what the DUT sampled. Outputs are checked 1ns after the falling edge.
   task automatic tick();
      logic [7:0]  ec, oc;
      logic [15:0] ema, emd, efa, efd;
      logic        vnow, post_rst;
      rd_t         r;
      @(negedge clk);
      cyc++;
      if (rst) op = NONE;
      else if (op == NONE && p_idle) begin
         if (d_wr_req) begin
            op = ST; s_addr = d_wr_addr; s_data = d_wr_data;
         end else if (d_req || i_req) begin
            op = FILL; f_d = d_req; m_t = 1; m_rx = 0;
            f_base = (d_req ? d_addr : i_addr) & ~16'(2 * WORDS - 1);
         end
      end
      if (mem_enable && mem_wr) mem_w[mem_addr] = mem_data_in;
      if (mem_enable && !mem_wr) rq.push_back('{cyc + MEM_LAT, mword(mem_addr)});
      vnow = rq.size() > 0 && rq[0].due <= cyc && (!jitter || $urandom_range(2) != 0);
      mem_data_valid = vnow;
      if (vnow) begin
         r = rq.pop_front();
         mem_data_out = r.d;
      end else mem_data_out = 16'($urandom);
      #1;
      ec = 0; ema = 0; emd = 0; efa = 0; efd = 0;
      post_rst = p_rst && !rst;
      if (!rst && op == ST) begin
         ec = 8'b1001_0011; ema = s_addr; emd = s_data;
      end else if (!rst && op == FILL) begin
         ec[7] = 1;
         if (m_rx == WORDS) ec[f_d ? 5 : 6] = 1;
         else begin
            if (m_t <= WORDS) begin ec[1] = 1; ema = f_base + 16'(2 * (m_t - 1)); end
            if (vnow) begin ec[f_d ? 2 : 3] = 1; efa = f_base + 16'(2 * m_rx); efd = mword(efa); end
         end
      end
      oc = {busy, i_done, d_done, d_wr_done, i_fill_we, d_fill_we, mem_enable, mem_wr};
      chk("ctl{busy,idone,ddone,wrdone,iwe,dwe,en,wr}", 16'(oc), 16'(ec));
      if (rst || post_rst) begin
         chk("rst_mem_addr", mem_addr, 16'h0);
         chk("rst_mem_data_in", mem_data_in, 16'h0);
         chk("rst_fill_addr", fill_addr, 16'h0);
         chk("rst_fill_data", fill_data, 16'h0);
      end else begin
         if (ec[1]) chk("mem_addr", mem_addr, ema);
         if (ec[0]) chk("mem_data_in", mem_data_in, emd);
         if (ec[3] || ec[2]) begin
            chk("fill_addr", fill_addr, efa);
            chk("fill_data", fill_data, efd);
         end
      end
      p_idle = op == NONE;
      p_rst = rst;
      if (!rst) case (op)
         ST: begin op = NONE; d_wr_req = 0; done_log.push_back(1); end
         FILL: begin
            if (m_rx == WORDS) begin
               if (!jitter) chk("fill_latency", 16'(m_t), 16'(WORDS + MEM_LAT + 1));
               done_log.push_back(f_d ? 2 : 3);
               if (f_d) d_req = 0; else i_req = 0;
               op = NONE;
            end else if (vnow) m_rx++;
            m_t++;
         end
         default: ;
      endcase
   endtask

   task automatic run_idle(input int n);
      int k = 0;
      while ((i_req || d_req || d_wr_req || op != NONE) && k < n) begin tick(); k++; end
      if (k >= n) chk("timeout", 16'd1, 16'd0);
      repeat (2) tick();
   endtask

   initial begin
      repeat (3) tick();
      rst = 0;
      tick();
      // single I fill with unaligned address
      done_log.delete();
      i_req = 1; i_addr = 16'h1236;
      run_idle(40);
      chk("i_fill_order", log_code(), 16'h0003);
      // simultaneous requests resolve store, D, I
      done_log.delete();
      d_wr_req = 1; d_wr_addr = 16'h0100; d_wr_data = 16'h1357;
      d_req = 1; d_addr = 16'h2000; i_req = 1; i_addr = 16'h3008;
      run_idle(100);
      chk("priority_order", log_code(), 16'h0123);
      // store arriving mid-fill waits for the fill
      done_log.delete();
      i_req = 1; i_addr = 16'h0104;
      repeat (3) tick();
      d_wr_req = 1; d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF;
      run_idle(60);
      chk("no_preempt_order", log_code(), 16'h0031);
      // refill of the stored-to block sees the new word
      done_log.delete();
      d_req = 1; d_addr = 16'h0046;
      run_idle(40);
      chk("refill_order", log_code(), 16'h0002);
      // top-of-memory block, no carry into 0x0000
      done_log.delete();
      d_req = 1; d_addr = 16'hFFFA;
      run_idle(40);
      chk("wrap_order", log_code(), 16'h0002);
      // reset in the middle of a D fill
      done_log.delete();
      d_req = 1; d_addr = 16'h4444;
      repeat (6) tick();
      rst = 1; d_req = 0;
      tick();
      rst = 0;
      repeat (10) tick();
      chk("reset_no_done", 16'(done_log.size()), 16'd0);
      // randomized traffic with jittered, in-order returns
      jitter = 1;
      for (int k = 0; k < 3000; k++) begin
         if (!i_req && $urandom_range(9) == 0) begin i_req = 1; i_addr = 16'($urandom); end
         if (!d_req && $urandom_range(9) == 0) begin d_req = 1; d_addr = 16'($urandom); end
         if (!d_wr_req && $urandom_range(14) == 0) begin
            d_wr_req = 1; d_wr_addr = 16'($urandom) & 16'hFFFE; d_wr_data = 16'($urandom);
         end
         if ($urandom_range(3) == 0) i_addr = 16'($urandom);
         if ($urandom_range(3) == 0) d_addr = 16'($urandom);
         tick();
      end
      run_idle(400);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
